// File: rtl/ps2_key_pkg.sv
// ---------------------------------------------------------------------------
// ps2_key_pkg
// Shared definitions for the PS/2 key decoder:
//   - KEY_TABLE  : the eight Set-2 make codes that can be mapped, in index order
//   - CODE_E0/F0 : extended and break prefix bytes
//   - state_t    : prefix FSM states
//   - key_lookup : returns {hit, index} for a code among the first num_keys entries
// ---------------------------------------------------------------------------
package ps2_key_pkg;

   localparam int MAX_KEYS = 8;

   localparam logic [7:0] CODE_E0 = 8'hE0;
   localparam logic [7:0] CODE_F0 = 8'hF0;

   // Packed so that entry i sits in bits [8*i +: 8]; entry 0 is 2B (F).
   localparam logic [MAX_KEYS-1:0][7:0] KEY_TABLE = {
      8'h23, 8'h21, 8'h32, 8'h1C, 8'h22, 8'h33, 8'h15, 8'h2B
   };

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_t;

   typedef struct packed {
      logic       hit;
      logic [2:0] idx;
   } lookup_t;

   function automatic lookup_t key_lookup(input logic [7:0] code, input int num_keys);
      lookup_t res;
      res = '0;
      for (int i = 0; i < MAX_KEYS; i++) begin
         if (i < num_keys && !res.hit && KEY_TABLE[i] == code) begin
            res.hit = 1'b1;
            res.idx = 3'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ps2_prefix_fsm.sv
// ---------------------------------------------------------------------------
// ps2_prefix_fsm
// Byte-accept edge detector, E0/F0 prefix state machine and prefix timeout.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_flag           : byte-valid level from the PS/2 receiver
//   i_scancode       : received byte (stable while i_flag is high)
//   o_make_evt       : combinational, high in the accept cycle of a plain make
//   o_brk_evt        : combinational, high in the accept cycle of a plain break
//   o_code           : byte that accompanies o_make_evt / o_brk_evt
//   o_seq_error      : registered one-cycle pulse on timeout or illegal prefix
// ---------------------------------------------------------------------------
module ps2_prefix_fsm
   import ps2_key_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_flag,
   input  logic [7:0] i_scancode,
   output logic       o_make_evt,
   output logic       o_brk_evt,
   output logic [7:0] o_code,
   output logic       o_seq_error
);

   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             r_flag_q;
   logic             r_seq_error;
   logic             w_err_next;
   logic             w_accept;

   // r_flag_q resets high so a flag already asserted at reset release is skipped.
   assign w_accept = i_flag && !r_flag_q;
   assign o_code   = i_scancode;
   assign o_seq_error = r_seq_error;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_flag_q    <= 1'b1;
         r_seq_error <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_flag_q    <= i_flag;
         r_seq_error <= w_err_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_err_next   = 1'b0;
      o_make_evt   = 1'b0;
      o_brk_evt    = 1'b0;
      // An accepted byte takes priority over a timeout expiring in the same cycle.
      if (w_accept) begin
         w_cnt_next = '0;
         case (r_state)
            ST_IDLE: begin
               if (i_scancode == CODE_E0)      w_state_next = ST_EXT;
               else if (i_scancode == CODE_F0) w_state_next = ST_BRK;
               else                            o_make_evt   = 1'b1;
            end
            ST_BRK: begin
               w_state_next = ST_IDLE;
               if (i_scancode == CODE_E0 || i_scancode == CODE_F0) w_err_next = 1'b1;
               else                                                o_brk_evt  = 1'b1;
            end
            ST_EXT: begin
               if (i_scancode == CODE_F0) w_state_next = ST_EXT_BRK;
               else                       w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
         endcase
      end else if (r_state != ST_IDLE) begin
         if (r_cnt == CNT_LAST) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
            w_err_next   = 1'b1;
         end else begin
            w_cnt_next = r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Turns PS/2 Set-2 bytes into glyph-address events for the character renderer.
// Ports:
//   vga_clk, rst_n    : pixel clock, asynchronous active-low reset
//   flag, scancode    : byte-valid level and byte from the PS/2 receiver
//   start_address_out : glyph start address of the last accepted make
//   char_enable       : one-cycle pulse on an accepted, non-suppressed make
//   key_held          : per-key pressed mask
//   break_pulse       : one-cycle pulse on the break of a held mapped key
//   seq_error         : one-cycle pulse on prefix timeout or illegal prefix
// ---------------------------------------------------------------------------
module ps2_key_decoder
   import ps2_key_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int ADDR_W          = 6,
   parameter int GLYPH_STRIDE    = 16,
   parameter int REPEAT_SUPPRESS = 1,
   parameter int TIMEOUT_CYC     = 1_000_000
) (
   input  logic                vga_clk,
   input  logic                rst_n,
   input  logic                flag,
   input  logic [7:0]          scancode,
   output logic [ADDR_W-1:0]   start_address_out,
   output logic                char_enable,
   output logic [NUM_KEYS-1:0] key_held,
   output logic                break_pulse,
   output logic                seq_error
);

   if (NUM_KEYS < 1 || NUM_KEYS > MAX_KEYS) begin : g_bad_num_keys
      $error("ps2_key_decoder: NUM_KEYS must be in 1..8");
   end
   if (NUM_KEYS * GLYPH_STRIDE > 2 ** ADDR_W) begin : g_bad_addr_w
      $error("ps2_key_decoder: glyph addresses do not fit in ADDR_W bits");
   end

   logic                w_make_evt;
   logic                w_brk_evt;
   logic [7:0]          w_code;
   lookup_t             w_lk;
   logic [NUM_KEYS-1:0] w_key_hot;
   logic                w_was_held;
   logic [ADDR_W-1:0]   w_addr;

   logic [ADDR_W-1:0]   r_addr;
   logic                r_char_enable;
   logic                r_break_pulse;
   logic [NUM_KEYS-1:0] r_key_held;

   ps2_prefix_fsm #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_fsm (
      .i_clk       (vga_clk),
      .i_rst_n     (rst_n),
      .i_flag      (flag),
      .i_scancode  (scancode),
      .o_make_evt  (w_make_evt),
      .o_brk_evt   (w_brk_evt),
      .o_code      (w_code),
      .o_seq_error (seq_error)
   );

   assign w_lk = key_lookup(w_code, NUM_KEYS);

   // One-hot of the looked-up key; all zero for an unmapped code.
   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_hot
      assign w_key_hot[gi] = w_lk.hit && (w_lk.idx == 3'(gi));
   end

   assign w_was_held = |(r_key_held & w_key_hot);
   assign w_addr     = ADDR_W'(w_lk.idx) * ADDR_W'(GLYPH_STRIDE);

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr        <= '0;
         r_char_enable <= 1'b0;
         r_break_pulse <= 1'b0;
         r_key_held    <= '0;
      end else begin
         r_char_enable <= 1'b0;
         r_break_pulse <= 1'b0;
         if (w_make_evt && w_lk.hit) begin
            r_key_held <= r_key_held | w_key_hot;
            if (!w_was_held || REPEAT_SUPPRESS == 0) begin
               r_addr        <= w_addr;
               r_char_enable <= 1'b1;
            end
         end else if (w_brk_evt && w_was_held) begin
            r_key_held    <= r_key_held & ~w_key_hot;
            r_break_pulse <= 1'b1;
         end
      end
   end

   assign start_address_out = r_addr;
   assign char_enable       = r_char_enable;
   assign break_pulse       = r_break_pulse;
   assign key_held          = r_key_held;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

   localparam int TMO = 20;

   logic       clk;
   logic       rst_n;
   logic       flag;
   logic [7:0] scancode;

   logic [5:0] addr_a, addr_b;
   logic       ce_a, ce_b, bp_a, bp_b, se_a, se_b;
   logic [3:0] held_a, held_b;

   int checks = 0;
   int errors = 0;

   logic       c_ce, c_bp, c_se, c_ce_b, c2_ce, c2_bp, c2_se;
   logic [5:0] c_addr, c_addr_b;
   logic [3:0] c_held;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   ps2_key_decoder #(
      .NUM_KEYS(4), .ADDR_W(6), .GLYPH_STRIDE(16), .REPEAT_SUPPRESS(1), .TIMEOUT_CYC(TMO)
   ) dut (
      .vga_clk(clk), .rst_n(rst_n), .flag(flag), .scancode(scancode),
      .start_address_out(addr_a), .char_enable(ce_a), .key_held(held_a),
      .break_pulse(bp_a), .seq_error(se_a)
   );

   ps2_key_decoder #(
      .NUM_KEYS(4), .ADDR_W(6), .GLYPH_STRIDE(16), .REPEAT_SUPPRESS(0), .TIMEOUT_CYC(TMO)
   ) dut_nr (
      .vga_clk(clk), .rst_n(rst_n), .flag(flag), .scancode(scancode),
      .start_address_out(addr_b), .char_enable(ce_b), .key_held(held_b),
      .break_pulse(bp_b), .seq_error(se_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic send(input logic [7:0] c);
      @(negedge clk);
      scancode = c;
      flag     = 1'b1;
      @(negedge clk);
      c_ce = ce_a; c_bp = bp_a; c_se = se_a; c_addr = addr_a; c_held = held_a;
      c_ce_b = ce_b; c_addr_b = addr_b;
      flag = 1'b0;
      @(negedge clk);
      c2_ce = ce_a; c2_bp = bp_a; c2_se = se_a;
      $display("byte %02h: ce=%0b bp=%0b se=%0b addr=%06b held=%04b", c, c_ce, c_bp, c_se, c_addr, c_held);
   endtask

   int n_pulse;
   int seen_at;

   initial begin
      rst_n = 1'b0; flag = 1'b1; scancode = 8'h15;
      #3;
      chk("rst_addr", addr_a, 6'd0);
      chk("rst_ce", ce_a, 1'b0);
      chk("rst_held", held_a, 4'b0000);
      chk("rst_bp", bp_a, 1'b0);
      chk("rst_se", se_a, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      n_pulse = 0;
      repeat (4) begin @(negedge clk); if (ce_a) n_pulse++; end
      chk("flag_high_at_release_pulses", n_pulse, 0);
      chk("flag_high_at_release_held", held_a, 4'b0000);
      flag = 1'b0;
      @(negedge clk);

      send(8'h15);
      chk("make_q_ce", c_ce, 1'b1);
      chk("make_q_addr", c_addr, 6'b010000);
      chk("make_q_held", c_held, 4'b0010);
      chk("make_q_ce_one_cycle", c2_ce, 1'b0);
      chk("make_q_nr_ce", c_ce_b, 1'b1);

      send(8'h15);
      chk("repeat_suppressed", c_ce, 1'b0);
      chk("repeat_nr_ce", c_ce_b, 1'b1);
      chk("repeat_nr_addr", c_addr_b, 6'b010000);

      send(8'hF0);
      chk("f0_no_bp", c_bp, 1'b0);
      send(8'h15);
      chk("break_q_bp", c_bp, 1'b1);
      chk("break_q_ce", c_ce, 1'b0);
      chk("break_q_held", c_held, 4'b0000);
      chk("break_q_bp_one_cycle", c2_bp, 1'b0);
      send(8'hF0);
      send(8'h15);
      chk("break_released_no_bp", c_bp, 1'b0);

      send(8'hE0);
      send(8'h2B);
      chk("ext_make_ce", c_ce, 1'b0);
      chk("ext_make_held", c_held, 4'b0000);
      send(8'hE0);
      send(8'hF0);
      send(8'h2B);
      chk("ext_brk_ce", c_ce, 1'b0);
      chk("ext_brk_bp", c_bp, 1'b0);
      send(8'h2B);
      chk("make_f_ce", c_ce, 1'b1);
      chk("make_f_addr", c_addr, 6'b000000);
      chk("make_f_held", c_held, 4'b0001);

      send(8'hF0);
      n_pulse = 0; seen_at = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (se_a) begin n_pulse++; if (seen_at < 0) seen_at = i; end
      end
      $display("timeout: seq_error pulses=%0d first at poll %0d", n_pulse, seen_at);
      chk("timeout_pulses", n_pulse, 1);
      chk("timeout_cycle", seen_at, 18);
      chk("timeout_held_kept", held_a, 4'b0001);
      send(8'h22);
      chk("after_timeout_ce", c_ce, 1'b1);
      chk("after_timeout_addr", c_addr, 6'b110000);
      chk("after_timeout_held", c_held, 4'b1001);

      send(8'hF0);
      send(8'hE0);
      chk("illegal_se", c_se, 1'b1);
      chk("illegal_se_one_cycle", c2_se, 1'b0);
      chk("illegal_bp", c_bp, 1'b0);
      send(8'h15);
      chk("after_illegal_ce", c_ce, 1'b1);
      chk("after_illegal_held", c_held, 4'b1011);

      @(negedge clk);
      scancode = 8'h33; flag = 1'b1;
      n_pulse = 0;
      repeat (50) begin @(negedge clk); if (ce_a) n_pulse++; end
      flag = 1'b0;
      @(negedge clk);
      $display("long flag 33: ce pulses=%0d addr=%06b held=%04b", n_pulse, addr_a, held_a);
      chk("long_flag_pulses", n_pulse, 1);
      chk("long_flag_addr", addr_a, 6'b100000);
      chk("long_flag_held", held_a, 4'b1111);

      send(8'h1C);
      chk("unmapped_ce", c_ce, 1'b0);
      chk("unmapped_held", c_held, 4'b1111);
      send(8'hAA);
      chk("aa_ce", c_ce, 1'b0);
      chk("aa_addr", c_addr, 6'b100000);

      send(8'hF0);
      #2 rst_n = 1'b0;
      #1;
      $display("async reset: addr=%06b held=%04b ce=%0b", addr_a, held_a, ce_a);
      chk("async_rst_held", held_a, 4'b0000);
      chk("async_rst_addr", addr_a, 6'd0);
      chk("async_rst_nr_held", held_b, 4'b0000);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      send(8'h15);
      chk("post_rst_make_ce", c_ce, 1'b1);
      chk("post_rst_make_addr", c_addr, 6'b010000);
      chk("post_rst_make_held", c_held, 4'b0010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
